fb_seq_ctrl: RTL and testbench
==============================

// Module: fb_seq_ctrl
// PURPOSE
//  Sequencer for the start/photon counter (count1) in the real-time feedback path.
//  Programs the counter limits and resets the counter.
//  Runs cfg_nseq measurement windows. Each window closes on the last start plus a cntstop hold-off.
//  At each window end it latches the photon count, compares it to a threshold and emits one
//  feedback decision. It then clears the counter for the next window.
// PARAMETERS
//  RST_PULSE  4         high cycles of count_rst/start_rst/photo_rst pulses (>=2, counter needs 2-sample detect)
//  SETTLE     4         wait cycles after a reset pulse before trusting counter outputs
//  TO_W       32        width of watchdog counter
//  TIMEOUT    32'hFFFF_FFFF  max clk500 cycles spent in RUN per window
// PORTS
//  clk500         in   1   500 MHz system clock
//  rst_n          in   1   asynchronous, active-low reset
//  cfg_go         in   1   1-cycle pulse: start a run (ignored unless IDLE or DONE)
//  cfg_abort      in   1   level/pulse: abandon run, return to IDLE
//  cfg_cntstart   in   24  starts per window (0 illegal -> treated as 1)
//  cfg_cntstop    in   32  hold-off cycles after last start
//  cfg_thresh     in   24  photon threshold
//  cfg_nseq       in   16  windows per run (0 -> run ends immediately in DONE)
//  count_rst      out  1   counter reset, active high
//  start_rst      out  1   counter start/sequence reset, active high
//  photo_rst      out  1   counter photon reset, active high
//  cntstart       out  24  to counter; registered copy of cfg_cntstart, frozen for the run
//  cntstop        out  32  to counter; registered copy of cfg_cntstop, frozen for the run
//  cnt_start      in   24  counter start count
//  cnt_photo      in   24  counter photon count
//  ready          in   1   counter ready (0 = stop hold-off elapsed)
//  fb_valid       out  1   1-cycle strobe: decision available
//  fb_result      out  1   1 if photons >= cfg_thresh; held until next fb_valid
//  fb_photons     out  24  latched cnt_photo; held until next fb_valid
//  seq_idx        out  16  index of current window (0-based)
//  busy           out  1   high in any state except IDLE/DONE
//  done           out  1   high in DONE
//  err_timeout    out  1   sticky; cleared by cfg_go or reset
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE.
//   count_rst=1, start_rst=0, photo_rst=0, all other outputs 0.
//   cntstart=1, cntstop=0.
//  States: IDLE, INIT, SETTLE, RUN, SAMPLE, DECIDE, CLEAR, DONE.
//  IDLE/DONE + cfg_go:
//   - latch cfg_* into cntstart/cntstop/thresh/nseq
//   - clear seq_idx and err_timeout -> INIT
//  INIT: count_rst=1 for RST_PULSE cycles -> SETTLE.
//  SETTLE: all resets low; after SETTLE cycles:
//   - -> DONE if nseq==0
//   - -> RUN otherwise
//  RUN: watchdog counts each cycle.
//   - Exit when cnt_start==cntstart && ready==0, sampled the same cycle -> SAMPLE.
//   - Watchdog reaching TIMEOUT -> set err_timeout -> DONE.
//  SAMPLE: fb_photons<=cnt_photo -> DECIDE.
//  DECIDE: fb_result<=(fb_photons>=thresh), unsigned 24-bit compare; fb_valid=1 for this cycle only.
//   - seq_idx+1==nseq -> DONE, seq_idx unchanged.
//   - otherwise -> CLEAR.
//  CLEAR: start_rst=photo_rst=1 for RST_PULSE cycles; seq_idx increments once on entry.
//   - Then SETTLE, which re-enters RUN (nseq!=0 here).
//  Latency: window-end condition to fb_valid = 2 cycles.
//  cfg_abort in any non-IDLE state:
//   - next cycle state=IDLE, count_rst=1, fb_valid suppressed, err_timeout kept.
//   - Abort wins over a simultaneous cfg_go.
//  count_rst held 1 in IDLE (counter parked); 0 in DONE (counts stay readable).
//  cfg_* changes mid-run have no effect until next cfg_go.
//  seq_idx is 16-bit and never wraps (bounded by nseq).
//  All outputs registered; no combinational input->output paths.
// TESTING
//  1. nseq=3, cntstart=5, cntstop=100; 5 starts/window, photons 7,2,9; thresh=5.
//     -> 3 fb_valid; results 1,0,1; photons 7,2,9; then done=1.
//  2. cntstart=4 but only 3 starts; TIMEOUT=1000.
//     -> err_timeout=1 after 1000 RUN cycles, done=1, no fb_valid.
//  3. Abort while in CLEAR mid-pulse.
//     -> next cycle IDLE, count_rst=1, start_rst=photo_rst=0, busy=0.
//  4. nseq=0 + cfg_go.
//     -> INIT, SETTLE, DONE; zero fb_valid; done=1.
//  5. rst_n low during RUN.
//     -> immediately IDLE, all outputs at reset values; fresh cfg_go runs normally.
//  6. Photons == thresh (thresh=9, 9 photons) -> fb_result=1; thresh=10 -> 0.

Source files
------------

// File: rtl/fb_seq_ctrl.sv
// Window sequencer for the start/photon counter in the real-time feedback path:
// programs and resets the counter, closes each window and emits one threshold decision per window.
module fb_seq_ctrl #(
  parameter int              RST_PULSE = 4,
  parameter int              SETTLE    = 4,
  parameter int              TO_W      = 32,
  parameter logic [TO_W-1:0] TIMEOUT   = 32'hFFFF_FFFF
) (
  input  logic        clk500,
  input  logic        rst_n,
  input  logic        cfg_go,
  input  logic        cfg_abort,
  input  logic [23:0] cfg_cntstart,
  input  logic [31:0] cfg_cntstop,
  input  logic [23:0] cfg_thresh,
  input  logic [15:0] cfg_nseq,
  output logic        count_rst,
  output logic        start_rst,
  output logic        photo_rst,
  output logic [23:0] cntstart,
  output logic [31:0] cntstop,
  input  logic [23:0] cnt_start,
  input  logic [23:0] cnt_photo,
  input  logic        ready,
  output logic        fb_valid,
  output logic        fb_result,
  output logic [23:0] fb_photons,
  output logic [15:0] seq_idx,
  output logic        busy,
  output logic        done,
  output logic        err_timeout
);

  localparam int PMAX = (RST_PULSE > SETTLE) ? RST_PULSE : SETTLE;
  localparam int CW   = $clog2(PMAX + 1);
  localparam logic [CW-1:0]   PULSE_LAST  = CW'(RST_PULSE - 1);
  localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [TO_W-1:0] WD_LAST     = TIMEOUT - 1'b1;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_SETTLE, S_RUN, S_SAMPLE, S_DECIDE, S_CLEAR, S_DONE
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [TO_W-1:0] r_wdog;
  logic [23:0]     r_thresh;
  logic [15:0]     r_nseq;

  logic w_win_end;
  logic w_last;

  assign w_win_end = (cnt_start == cntstart) && !ready;
  // 17-bit compare so seq_idx+1 cannot wrap against nseq
  assign w_last    = ({1'b0, seq_idx} + 17'd1) == {1'b0, r_nseq};

  always_ff @(posedge clk500 or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_wdog      <= '0;
      r_thresh    <= '0;
      r_nseq      <= '0;
      count_rst   <= 1'b1;
      start_rst   <= 1'b0;
      photo_rst   <= 1'b0;
      cntstart    <= 24'd1;
      cntstop     <= '0;
      fb_valid    <= 1'b0;
      fb_result   <= 1'b0;
      fb_photons  <= '0;
      seq_idx     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      fb_valid <= 1'b0;
      if (cfg_abort && r_state != S_IDLE) begin
        r_state   <= S_IDLE;
        count_rst <= 1'b1;
        start_rst <= 1'b0;
        photo_rst <= 1'b0;
        busy      <= 1'b0;
        done      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (cfg_go && !cfg_abort) begin
              cntstart    <= (cfg_cntstart == 24'd0) ? 24'd1 : cfg_cntstart;
              cntstop     <= cfg_cntstop;
              r_thresh    <= cfg_thresh;
              r_nseq      <= cfg_nseq;
              seq_idx     <= '0;
              err_timeout <= 1'b0;
              r_cnt       <= '0;
              count_rst   <= 1'b1;
              busy        <= 1'b1;
              done        <= 1'b0;
              r_state     <= S_INIT;
            end
          end
          S_INIT: begin
            if (r_cnt == PULSE_LAST) begin
              count_rst <= 1'b0;
              r_cnt     <= '0;
              r_state   <= S_SETTLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_SETTLE: begin
            if (r_cnt == SETTLE_LAST) begin
              r_cnt <= '0;
              if (r_nseq == 16'd0) begin
                busy    <= 1'b0;
                done    <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_wdog  <= '0;
                r_state <= S_RUN;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_RUN: begin
            if (w_win_end) begin
              r_state <= S_SAMPLE;
            end else if (r_wdog == WD_LAST) begin
              err_timeout <= 1'b1;
              busy        <= 1'b0;
              done        <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_wdog <= r_wdog + 1'b1;
            end
          end
          S_SAMPLE: begin
            // Decision is formed from the same sample being latched, so fb_result
            // is already valid in the cycle fb_valid is high.
            fb_photons <= cnt_photo;
            fb_result  <= (cnt_photo >= r_thresh);
            fb_valid   <= 1'b1;
            r_state    <= S_DECIDE;
          end
          S_DECIDE: begin
            if (w_last) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              seq_idx   <= seq_idx + 1'b1;
              start_rst <= 1'b1;
              photo_rst <= 1'b1;
              r_cnt     <= '0;
              r_state   <= S_CLEAR;
            end
          end
          S_CLEAR: begin
            if (r_cnt == PULSE_LAST) begin
              start_rst <= 1'b0;
              photo_rst <= 1'b0;
              r_cnt     <= '0;
              r_state   <= S_SETTLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fb_seq_ctrl.sv
// Scoreboard bench for fb_seq_ctrl: stimulus pushes expected decisions, a negedge monitor checks them.
module tb_fb_seq_ctrl;

  logic        clk500 = 1'b0;
  logic        rst_n;
  logic        cfg_go, cfg_abort;
  logic [23:0] cfg_cntstart, cfg_thresh;
  logic [31:0] cfg_cntstop;
  logic [15:0] cfg_nseq;
  logic        count_rst, start_rst, photo_rst;
  logic [23:0] cntstart;
  logic [31:0] cntstop;
  logic [23:0] cnt_start, cnt_photo;
  logic        ready;
  logic        fb_valid, fb_result;
  logic [23:0] fb_photons;
  logic [15:0] seq_idx;
  logic        busy, done, err_timeout;

  fb_seq_ctrl #(.RST_PULSE(4), .SETTLE(4), .TO_W(32), .TIMEOUT(32'd1000)) dut (
    .clk500(clk500), .rst_n(rst_n), .cfg_go(cfg_go), .cfg_abort(cfg_abort),
    .cfg_cntstart(cfg_cntstart), .cfg_cntstop(cfg_cntstop), .cfg_thresh(cfg_thresh),
    .cfg_nseq(cfg_nseq), .count_rst(count_rst), .start_rst(start_rst),
    .photo_rst(photo_rst), .cntstart(cntstart), .cntstop(cntstop),
    .cnt_start(cnt_start), .cnt_photo(cnt_photo), .ready(ready),
    .fb_valid(fb_valid), .fb_result(fb_result), .fb_photons(fb_photons),
    .seq_idx(seq_idx), .busy(busy), .done(done), .err_timeout(err_timeout)
  );

  always #5 clk500 = ~clk500;

  typedef struct { logic res; logic [23:0] ph; } exp_t;
  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;
  int n_fb  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic tick();
    @(posedge clk500);
    #1;
  endtask

  // Monitor: every fb_valid strobe must match the oldest queued expectation.
  initial forever begin
    exp_t e;
    @(negedge clk500);
    if (fb_valid) begin
      n_fb++;
      if (exp_q.size() == 0) begin
        fail("fb_unexpected");
      end else begin
        e = exp_q.pop_front();
        chk("fb_result", {31'd0, fb_result}, {31'd0, e.res});
        chk("fb_photons", {8'd0, fb_photons}, {8'd0, e.ph});
      end
    end
  end

  task automatic push(input logic r, input logic [23:0] p);
    exp_t e;
    e.res = r;
    e.ph  = p;
    exp_q.push_back(e);
  endtask

  task automatic go(input logic [23:0] cs, input logic [31:0] cp,
                    input logic [23:0] th, input logic [15:0] ns);
    cfg_cntstart = cs; cfg_cntstop = cp; cfg_thresh = th; cfg_nseq = ns;
    cfg_go = 1'b1;
    tick();
    cfg_go = 1'b0;
  endtask

  // Counter stand-in: present a closed window, hold until the DUT clears or finishes.
  task automatic window(input logic [23:0] n, input logic [23:0] ph);
    int k;
    k = 0;
    while ((count_rst || start_rst) && k < 200) begin tick(); k++; end
    if (k >= 200) fail("wait_resets_low");
    cnt_start = n; cnt_photo = ph; ready = 1'b0;
    k = 0;
    while (!start_rst && !done && k < 200) begin tick(); k++; end
    if (k >= 200) fail("wait_window_close");
    cnt_start = '0; cnt_photo = '0; ready = 1'b1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 2000) begin tick(); n++; end
    if (n >= 2000) fail("wait_done");
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation bound expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n, fb0;
    rst_n = 1'b0; cfg_go = 1'b0; cfg_abort = 1'b0;
    cfg_cntstart = '0; cfg_cntstop = '0; cfg_thresh = '0; cfg_nseq = '0;
    cnt_start = '0; cnt_photo = '0; ready = 1'b1;
    repeat (3) tick();
    chk("rst_count_rst", {31'd0, count_rst}, 1);
    chk("rst_start_photo", {30'd0, start_rst, photo_rst}, 0);
    chk("rst_cntstart", {8'd0, cntstart}, 1);
    chk("rst_cntstop", cntstop, 0);
    chk("rst_busy_done_err", {29'd0, busy, done, err_timeout}, 0);
    rst_n = 1'b1;
    tick();

    // 1: three windows; cfg changes after go must not leak into the run
    push(1'b1, 24'd7); push(1'b0, 24'd2); push(1'b1, 24'd9);
    go(24'd5, 32'd100, 24'd5, 16'd3);
    cfg_thresh = 24'd0; cfg_cntstart = 24'd77; cfg_nseq = 16'd9;
    chk("t1_busy", {31'd0, busy}, 1);
    chk("t1_cntstart", {8'd0, cntstart}, 5);
    chk("t1_cntstop", cntstop, 100);
    window(24'd5, 24'd7);
    window(24'd5, 24'd2);
    window(24'd5, 24'd9);
    wait_done(n);
    tick();
    chk("t1_done", {31'd0, done}, 1);
    chk("t1_nfb", n_fb, 3);
    chk("t1_seq_idx", {16'd0, seq_idx}, 2);
    chk("t1_count_rst_done", {31'd0, count_rst}, 0);

    // 2: too few starts -> watchdog; 4 INIT + 4 SETTLE + 1000 RUN cycles
    fb0 = n_fb;
    cnt_start = 24'd3; cnt_photo = 24'd1; ready = 1'b0;
    go(24'd4, 32'd50, 24'd1, 16'd2);
    wait_done(n);
    cnt_start = '0; cnt_photo = '0; ready = 1'b1;
    chk("t2_cycles", n, 1008);
    chk("t2_err", {31'd0, err_timeout}, 1);
    chk("t2_nfb", n_fb - fb0, 0);

    // 4: nseq=0 goes straight through INIT/SETTLE to DONE, err cleared by go
    fb0 = n_fb;
    go(24'd4, 32'd50, 24'd1, 16'd0);
    chk("t4_err_cleared", {31'd0, err_timeout}, 0);
    wait_done(n);
    chk("t4_cycles", n, 8);
    tick();
    chk("t4_nfb", n_fb - fb0, 0);

    // 6: equality boundary, plus cntstart=0 treated as 1
    push(1'b1, 24'd9);
    go(24'd3, 32'd10, 24'd9, 16'd1);
    window(24'd3, 24'd9);
    wait_done(n);
    push(1'b0, 24'd9);
    go(24'd0, 32'd10, 24'd10, 16'd1);
    chk("t6_cntstart_zero", {8'd0, cntstart}, 1);
    window(24'd1, 24'd9);
    wait_done(n);
    tick();

    // 3: abort in the middle of the CLEAR pulse
    push(1'b1, 24'd5);
    go(24'd2, 32'd10, 24'd3, 16'd2);
    window(24'd2, 24'd5);
    chk("t3_in_clear", {31'd0, start_rst}, 1);
    tick();
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    chk("t3_count_rst", {31'd0, count_rst}, 1);
    chk("t3_start_photo", {30'd0, start_rst, photo_rst}, 0);
    chk("t3_busy_done", {30'd0, busy, done}, 0);

    // 5: async reset during RUN, then a fresh run
    go(24'd2, 32'd10, 24'd3, 16'd2);
    n = 0;
    while (count_rst && n < 50) begin tick(); n++; end
    repeat (6) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_count_rst", {31'd0, count_rst}, 1);
    chk("t5_busy_done_err", {29'd0, busy, done, err_timeout}, 0);
    chk("t5_cntstart", {8'd0, cntstart}, 1);
    chk("t5_seq_fbv", {15'd0, seq_idx, fb_valid}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    push(1'b1, 24'd4);
    go(24'd2, 32'd10, 24'd3, 16'd1);
    window(24'd2, 24'd4);
    wait_done(n);
    tick();
    chk("t5_done", {31'd0, done}, 1);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
